serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 114 +++++++++++
 tb/tb_serial_adder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Digit-serial add/subtract unit: WIDTH-bit operands are consumed DIGIT bits per clock,
// LSB digit first, with the inter-digit carry held in a register.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             state_dbg
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder: DIGIT must divide WIDTH exactly");
    end

    // Handshake: start is taken only while busy=0; done pulses for the single cycle in
    // which sum/cout/ovf have just been updated, which is also the first idle cycle.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_next;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [DIGIT:0]   dsum;
    logic             msb_cin;
    logic             last;

    always_comb begin
        dsum     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
        // Carry into the top bit of this digit, recovered from its sum bit and operand bits.
        msb_cin  = dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
        res_next = res_q >> DIGIT;
        res_next[WIDTH-1 -: DIGIT] = dsum[DIGIT-1:0];
        last     = (cnt_q == CW'(STEPS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == RUN);
        state_dbg = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_q     <= a;
                    b_q     <= sub ? ~b : b;
                    carry_q <= sub | cin;
                    res_q   <= '0;
                    cnt_q   <= '0;
                end
            end else begin
                a_q     <= a_q >> DIGIT;
                b_q     <= b_q >> DIGIT;
                carry_q <= dsum[DIGIT];
                res_q   <= res_next;
                cnt_q   <= cnt_q + CW'(1);
                if (last) begin
                    sum  <= res_next;
                    cout <= dsum[DIGIT];
                    ovf  <= msb_cin ^ dsum[DIGIT];
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: several WIDTH/DIGIT instances run side by side, each checked
// every cycle against an arithmetic reference plus a few hand-computed results.
module tb_serial_adder;
    localparam int NCFG = 7;
    localparam int CFG_W[NCFG] = '{8, 8, 8, 16, 16, 16, 6};
    localparam int CFG_D[NCFG] = '{1, 4, 2, 1, 4, 16, 3};
    localparam int CFG_N[NCFG] = '{300, 300, 300, 2000, 2000, 2000, 2000};

    localparam int NT = 4;
    localparam int        T_CFG[NT] = '{0, 1, 2, 2};
    localparam logic [15:0] T_A[NT] = '{16'h3C, 16'hFF, 16'h10, 16'h80};
    localparam logic [15:0] T_B[NT] = '{16'h5A, 16'h01, 16'h20, 16'h01};
    localparam logic        T_CI[NT] = '{1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic        T_SB[NT] = '{1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [15:0] T_S[NT] = '{16'h97, 16'h00, 16'hF0, 16'h7F};
    localparam logic        T_CO[NT] = '{1'b0, 1'b1, 1'b0, 1'b1};
    localparam logic        T_OV[NT] = '{1'b1, 1'b0, 1'b0, 1'b1};

    logic clk = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n_fin = 0;

    always #5 clk = ~clk;

    function automatic void chk(input int cfg, input string what, input longint act,
                                input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL cfg%0d %s: got 0x%0h, expected 0x%0h", cfg, what, act, exp);
        end
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int W = CFG_W[g];
        localparam int D = CFG_D[g];
        localparam int STEPS = W / D;

        logic         rst;
        logic         start;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic         busy;
        logic         done;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         state_dbg;

        serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
            .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
            .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
            .state_dbg(state_dbg)
        );

        // Returns {cout, ovf, sum} from plain integer arithmetic.
        function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic c, input logic s);
            longint ux, uy, sx, sy, full, r;
            logic   co, ov;
            ux = longint'(x);
            uy = longint'(y);
            sx = x[W-1] ? ux - (longint'(1) << W) : ux;
            sy = y[W-1] ? uy - (longint'(1) << W) : uy;
            if (s) begin
                full = ux - uy;
                co   = (ux >= uy);
                r    = sx - sy;
            end else begin
                full = ux + uy + longint'(c);
                co   = (full >> W) != 0;
                r    = sx + sy + longint'(c);
            end
            ov = (r > (longint'(1) << (W - 1)) - 1) || (r < -(longint'(1) << (W - 1)));
            return {co, ov, full[W-1:0]};
        endfunction

        function automatic logic [W-1:0] rnd();
            case ($urandom_range(0, 7))
                0:       return '0;
                1:       return '1;
                2:       return W'(1) << (W - 1);
                3:       return ~(W'(1) << (W - 1));
                default: return W'($urandom);
            endcase
        endfunction

        // Reference: cycles left in the running op, plus the held result registers.
        int           m_left = 0;
        logic         m_done = 1'b0;
        logic [W-1:0] m_sum = '0;
        logic         m_cout = 1'b0;
        logic         m_ovf = 1'b0;
        logic [W+1:0] m_pend = '0;

        always @(posedge clk) begin
            if (rst) begin
                m_left = 0;
                m_done = 1'b0;
                m_sum  = '0;
                m_cout = 1'b0;
                m_ovf  = 1'b0;
            end else begin
                m_done = 1'b0;
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_done = 1'b1;
                        {m_cout, m_ovf, m_sum} = m_pend;
                    end
                end else if (start) begin
                    m_pend = ref_op(a, b, cin, sub);
                    m_left = STEPS;
                end
            end
        end

        always @(negedge clk) begin
            chk(g, "cycle_outputs", {state_dbg, busy, done, cout, ovf, sum},
                {1'(m_left > 0), 1'(m_left > 0), m_done, m_cout, m_ovf, m_sum});
        end

        task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                              input logic s, input bit noise, output logic [W-1:0] o_sum,
                              output logic o_co, output logic o_ov);
            logic [W+1:0] e;
            int           lat;
            bit           seen;
            e = ref_op(x, y, c, s);
            a = x;
            b = y;
            cin = c;
            sub = s;
            start = 1'b1;
            @(posedge clk);
            lat = 1;
            seen = 1'b0;
            while (!seen && lat <= STEPS + 4) begin
                @(negedge clk);
                if (done) begin
                    seen = 1'b1;
                end else begin
                    start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                    if (noise) begin
                        a = rnd();
                        b = rnd();
                        cin = 1'($urandom_range(0, 1));
                        sub = 1'($urandom_range(0, 1));
                    end
                    @(posedge clk);
                    lat++;
                end
            end
            start = 1'b0;
            o_sum = sum;
            o_co  = cout;
            o_ov  = ovf;
            chk(g, seen ? "latency_edges" : "done_timeout", lat, STEPS + 1);
            chk(g, "op_result", {cout, ovf, sum}, e);
        endtask

        initial begin : drive
            logic [W-1:0] rs, x, y;
            logic         rc, ro, c, s;
            int           prev, nd, rst_at;
            rst = 1'b1;
            start = 1'b0;
            a = '0;
            b = '0;
            cin = 1'b0;
            sub = 1'b0;
            repeat (2) @(negedge clk);
            chk(g, "reset_outputs", {state_dbg, busy, done, cout, ovf, sum}, 0);
            rst = 1'b0;
            @(negedge clk);

            for (int i = 0; i < NT; i++) begin
                if (T_CFG[i] == g) begin
                    run_op(W'(T_A[i]), W'(T_B[i]), T_CI[i], T_SB[i], 1'b1, rs, rc, ro);
                    chk(g, "literal_result", {rc, ro, rs}, {T_CO[i], T_OV[i], W'(T_S[i])});
                end
            end

            // start held high: one completion every STEPS+1 cycles
            a = rnd();
            b = rnd();
            cin = 1'b1;
            sub = 1'b0;
            start = 1'b1;
            prev = -1;
            nd = 0;
            for (int i = 0; i < 3 * (STEPS + 1); i++) begin
                @(negedge clk);
                if (done) begin
                    if (prev >= 0) chk(g, "done_spacing", i - prev, STEPS + 1);
                    prev = i;
                    nd++;
                end
            end
            start = 1'b0;
            chk(g, "held_done_count", nd, 3);
            for (int k = 0; k < STEPS + 2 && busy; k++) @(negedge clk);

            // reset in the middle of an operation, with start also high
            rst_at = (STEPS < 4) ? STEPS : 4;
            a = W'(16'h7F);
            b = W'(16'h01);
            cin = 1'b0;
            sub = 1'b0;
            start = 1'b1;
            @(posedge clk);
            for (int i = 1; i <= rst_at; i++) begin
                @(negedge clk);
                start = 1'b0;
            end
            rst = 1'b1;
            start = 1'b1;
            @(negedge clk);
            chk(g, "reset_abort", {state_dbg, busy, done, cout, ovf, sum}, 0);
            rst = 1'b0;
            start = 1'b0;
            nd = 0;
            repeat (STEPS + 4) begin
                @(negedge clk);
                if (done) nd++;
            end
            chk(g, "no_done_after_abort", nd, 0);
            run_op(W'(16'h7F), W'(16'h01), 1'b0, 1'b0, 1'b0, rs, rc, ro);

            for (int n = 0; n < CFG_N[g]; n++) begin
                x = rnd();
                y = rnd();
                c = 1'($urandom_range(0, 1));
                s = 1'($urandom_range(0, 1));
                run_op(x, y, c, s, 1'($urandom_range(0, 1)), rs, rc, ro);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            n_fin++;
        end
    end

    initial begin
        fork
            wait (n_fin == NCFG);
            begin
                repeat (90000) @(posedge clk);
                chk(-1, "global_timeout", n_fin, NCFG);
            end
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
